barrel_shifter_pipe_amisha: RTL and testbench

//  Parametrised, pipelined barrel shifter: successor to the combinational 8-bit case-based rotator.

---
 rtl/barrel_shifter_pipe_amisha_if.sv | 45 ++++
 rtl/barrel_shifter_pipe_amisha.sv | 118 +++++++++++
 tb/tb_barrel_shifter_pipe_amisha.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shifter_pipe_amisha_if.sv
// ============================================================================
// Module  : barrel_shifter_pipe_amisha_if
// Purpose : Valid/ready operand and result bus for the pipelined barrel shifter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface barrel_shifter_pipe_amisha_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid_amisha;
  logic             in_ready_amisha;
  logic [WIDTH-1:0] a_amisha;
  logic [AMT_W-1:0] amt_amisha;
  logic [1:0]       mode_amisha;
  logic             out_valid_amisha;
  logic             out_ready_amisha;
  logic [WIDTH-1:0] y_amisha;

  modport master (
    output in_valid_amisha,
    output a_amisha,
    output amt_amisha,
    output mode_amisha,
    output out_ready_amisha,
    input  in_ready_amisha,
    input  out_valid_amisha,
    input  y_amisha
  );

  modport slave (
    input  in_valid_amisha,
    input  a_amisha,
    input  amt_amisha,
    input  mode_amisha,
    input  out_ready_amisha,
    output in_ready_amisha,
    output out_valid_amisha,
    output y_amisha
  );
endinterface

`default_nettype wire

// File: rtl/barrel_shifter_pipe_amisha.sv
// ============================================================================
// Module  : barrel_shifter_pipe_amisha
// Purpose : Pipelined ROR/ROL/LSR/ASR barrel shifter, one log2 stage per cycle.
//           Define BSH_XFER_CNT_EN to add the saturating output-transfer counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_shifter_pipe_amisha #(
  parameter int WIDTH = 8
) (
  input  wire logic                   clk_amisha,
  input  wire logic                   reset_amisha,
`ifdef BSH_XFER_CNT_EN
  output logic [15:0]                 xfer_cnt_amisha,
`endif
  barrel_shifter_pipe_amisha_if.slave bus
);

  localparam int         AMT_W      = $clog2(WIDTH);
  localparam logic [1:0] c_MODE_ROR = 2'b00;
  localparam logic [1:0] c_MODE_ROL = 2'b01;
  localparam logic [1:0] c_MODE_LSR = 2'b10;

  // Register 0 captures the raw operand; register s+1 holds the result of shift stage s.
  logic [AMT_W:0]   r_vld;
  logic [WIDTH-1:0] r_data  [AMT_W+1];
  logic [AMT_W-1:0] r_amt   [AMT_W];
  logic [1:0]       r_mode  [AMT_W];
  logic [AMT_W-1:0] r_sign;

  logic [AMT_W-1:0] w_step;
  logic [WIDTH-1:0] w_shift [AMT_W];
  logic             w_adv;

  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             sign,
    input int               k
  );
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> k) : '0;
    case (mode)
      c_MODE_ROR: f_shift = (d >> k) | (d << (WIDTH - k));
      c_MODE_ROL: f_shift = (d << k) | (d >> (WIDTH - k));
      c_MODE_LSR: f_shift = d >> k;
      default:    f_shift = (d >> k) | fill;
    endcase
  endfunction

  assign w_adv                = !r_vld[AMT_W] || bus.out_ready_amisha;
  assign bus.in_ready_amisha  = w_adv;
  assign bus.out_valid_amisha = r_vld[AMT_W];
  assign bus.y_amisha         = r_data[AMT_W];

  always_comb begin
    w_step = '0;
    for (int s = 0; s < AMT_W; s++) begin
      // amt is right-shifted one bit per stage, so in the last stage only bit 0 can be set.
      w_step[s]  = (s == AMT_W - 1) ? (|r_amt[s]) : r_amt[s][0];
      w_shift[s] = w_step[s] ? f_shift(r_data[s], r_mode[s], r_sign[s], 1 << s) : r_data[s];
    end
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      for (int s = 0; s <= AMT_W; s++) begin
        r_vld[s]  <= 1'b0;
        r_data[s] <= '0;
      end
      for (int s = 0; s < AMT_W; s++) begin
        r_amt[s]  <= '0;
        r_mode[s] <= '0;
        r_sign[s] <= 1'b0;
      end
    end else if (w_adv) begin
      r_vld[0] <= bus.in_valid_amisha;
      if (bus.in_valid_amisha) begin
        r_data[0] <= bus.a_amisha;
        r_amt[0]  <= bus.amt_amisha;
        r_mode[0] <= bus.mode_amisha;
        r_sign[0] <= bus.a_amisha[WIDTH-1];
      end
      // Bubbles leave data untouched so y holds its last value while out_valid is low.
      for (int s = 0; s < AMT_W; s++) begin
        r_vld[s+1] <= r_vld[s];
        if (r_vld[s]) begin
          r_data[s+1] <= w_shift[s];
        end
      end
      for (int s = 0; s < AMT_W - 1; s++) begin
        if (r_vld[s]) begin
          r_amt[s+1]  <= r_amt[s] >> 1;
          r_mode[s+1] <= r_mode[s];
          r_sign[s+1] <= r_sign[s];
        end
      end
    end
  end

`ifdef BSH_XFER_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_xfer_cnt <= '0;
    end else if (r_vld[AMT_W] && bus.out_ready_amisha && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt_amisha = r_xfer_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe_amisha.sv
// ============================================================================
// Module  : tb_barrel_shifter_pipe_amisha
// Purpose : Self-checking bench for barrel_shifter_pipe_amisha (WIDTH = 8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_barrel_shifter_pipe_amisha;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] exp;
    int         acc;
    bit         lat;
  } item_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  item_t q[$];

  barrel_shifter_pipe_amisha_if #(.WIDTH(WIDTH)) bus ();

`ifdef BSH_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  barrel_shifter_pipe_amisha #(.WIDTH(WIDTH)) dut (
    .clk_amisha      (clk),
    .reset_amisha    (rst),
`ifdef BSH_XFER_CNT_EN
    .xfer_cnt_amisha (xfer_cnt),
`endif
    .bus             (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: rotate via a doubled operand, shifts via plain arithmetic.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] n, input logic [1:0] m);
    logic [15:0]       t;
    logic signed [7:0] s;
    model = 8'h00;
    case (m)
      2'd0: begin t = {a, a} >> n; model = t[7:0];  end
      2'd1: begin t = {a, a} << n; model = t[15:8]; end
      2'd2: model = a >> n;
      default: begin s = a; model = s >>> n; end
    endcase
  endfunction

  // Output monitor: scoreboard compare, latency, stall stability.
  initial begin
    item_t      it;
    bit         prev_stall = 0;
    logic [7:0] prev_y = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'd0, bus.out_valid_amisha}, 32'd1);
          check("stall_y", {24'd0, bus.y_amisha}, {24'd0, prev_y});
        end
        if (bus.out_valid_amisha && !bus.out_ready_amisha)
          check("stall_in_ready", {31'd0, bus.in_ready_amisha}, 32'd0);
        if (bus.out_valid_amisha && bus.out_ready_amisha) begin
          if (q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            it = q.pop_front();
            check("result", {24'd0, bus.y_amisha}, {24'd0, it.exp});
            if (it.lat) check("latency", cyc - it.acc, 32'd3);
          end
        end
        prev_stall = bus.out_valid_amisha && !bus.out_ready_amisha;
        prev_y     = bus.y_amisha;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [2:0] n, input logic [1:0] m,
                      input logic [7:0] exp, input bit lat, output int waited);
    item_t it;
    bit    done = 0;
    waited = 0;
    bus.in_valid_amisha = 1'b1;
    bus.a_amisha        = a;
    bus.amt_amisha      = n;
    bus.mode_amisha     = m;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready_amisha) begin
        it.exp = exp; it.acc = cyc + 1; it.lat = lat;
        q.push_back(it);
        done = 1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid_amisha = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    int         w;
    int         sent;
    int         stall;
    bit         started;
    logic [7:0] ra;
    logic [2:0] rn;
    logic [1:0] rm;
    logic [7:0] modes_exp [4];
    logic [7:0] b2b_exp [5];
    logic [2:0] b2b_amt [5];

    modes_exp = '{8'h77, 8'hDD, 8'h17, 8'hF7};
    b2b_amt   = '{3'd5, 3'd3, 3'd1, 3'd4, 3'd2};
    b2b_exp   = '{8'hDD, 8'h77, 8'hDD, 8'hBB, 8'hEE};

    bus.in_valid_amisha  = 1'b0;
    bus.a_amisha         = '0;
    bus.amt_amisha       = '0;
    bus.mode_amisha      = '0;
    bus.out_ready_amisha = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid_amisha}, 32'd0);
    check("rst_y", {24'd0, bus.y_amisha}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready_amisha}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Four modes on 0xBB by 3, each isolated so latency is unambiguous
    for (int m = 0; m < 4; m++) begin
      send(8'hBB, 3'd3, m[1:0], modes_exp[m], 1'b1, w);
      drain();
    end

    // Back-to-back ROR
    for (int i = 0; i < 5; i++) begin
      send(8'hBB, b2b_amt[i], 2'd0, b2b_exp[i], 1'b1, w);
      check("b2b_in_ready_wait", w, 32'd0);
    end
    drain();

    // amt = 0 identity and full ASR
    for (int m = 0; m < 4; m++) send(8'h81, 3'd0, m[1:0], 8'h81, 1'b1, w);
    send(8'h80, 3'd7, 2'd3, 8'hFF, 1'b1, w);
    drain();

    // Asynchronous reset with two operands in flight
    send(8'h5A, 3'd2, 2'd1, 8'h00, 1'b0, w);
    send(8'hC3, 3'd1, 2'd0, 8'h00, 1'b0, w);
    #3 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid_amisha}, 32'd0);
    check("midrst_y", {24'd0, bus.y_amisha}, 32'd0);
    q.delete();
    @(negedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", {31'd0, bus.out_valid_amisha}, 32'd0);
    end
    @(posedge clk); #1;

`ifdef BSH_XFER_CNT_EN
    check("cnt_after_rst", {16'd0, xfer_cnt}, 32'd0);
    bus.out_ready_amisha = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom); rn = 3'($urandom); rm = 2'($urandom);
      send(ra, rn, rm, model(ra, rn, rm), 1'b0, w);
    end
    repeat (4) @(posedge clk);
    #1;
    check("cnt_stalled", {16'd0, xfer_cnt}, 32'd0);
    bus.out_ready_amisha = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ra = 8'($urandom); rn = 3'($urandom); rm = 2'($urandom);
      send(ra, rn, rm, model(ra, rn, rm), 1'b0, w);
    end
    drain();
    check("cnt_ten", {16'd0, xfer_cnt}, 32'd10);
`endif

    // Backpressure: six operands, four stall cycles once out_valid rises
    sent = 0; stall = 0; started = 0;
    ra = 8'($urandom); rn = 3'($urandom); rm = 2'($urandom);
    for (int c = 0; c < 60 && (sent < 6 || q.size() != 0); c++) begin
      bus.in_valid_amisha  = (sent < 6);
      bus.a_amisha         = ra;
      bus.amt_amisha       = rn;
      bus.mode_amisha      = rm;
      bus.out_ready_amisha = !(started && stall < 4);
      if (started && stall < 4) stall++;
      @(negedge clk);
      if (bus.in_valid_amisha && bus.in_ready_amisha) begin
        q.push_back('{exp: model(ra, rn, rm), acc: 0, lat: 1'b0});
        sent++;
        ra = 8'($urandom); rn = 3'($urandom); rm = 2'($urandom);
      end
      if (bus.out_valid_amisha) started = 1;
      @(posedge clk); #1;
    end
    bus.in_valid_amisha  = 1'b0;
    bus.out_ready_amisha = 1'b1;
    check("bp_sent", sent, 32'd6);
    check("bp_stalls", stall, 32'd4);
    drain();

    // Random traffic with random backpressure and bubbles
    sent = 0;
    for (int c = 0; c < 600 && (sent < 60 || q.size() != 0); c++) begin
      ra = 8'($urandom); rn = 3'($urandom); rm = 2'($urandom);
      bus.in_valid_amisha  = (sent < 60) && ($urandom_range(0, 3) != 0);
      bus.a_amisha         = ra;
      bus.amt_amisha       = rn;
      bus.mode_amisha      = rm;
      bus.out_ready_amisha = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_valid_amisha && bus.in_ready_amisha) begin
        q.push_back('{exp: model(ra, rn, rm), acc: 0, lat: 1'b0});
        sent++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid_amisha  = 1'b0;
    bus.out_ready_amisha = 1'b1;
    check("rand_sent", sent, 32'd60);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
